clbacc: RTL

- Downstream accumulation stage for the custom tile. Consumes the 16-bit Q stream from custmul (or clbalu) and sums a programmed number of signed terms into a wide accumulator.
- Scales, saturates and presents the result as a 16-bit word with a valid/ready handshake.
- Built for dot-product and FIR-style chains: custmul products flow into clbacc, and clbacc Q feeds the next clbalu I0.

---
 rtl/clbacc.sv | 139 +++++++++++++
 1 files changed

// File: rtl/clbacc.sv
// clbacc: signed multi-term accumulator with scaling, optional saturation and
// a valid/ready result handshake, sitting between custmul and the next clbalu.
//
// state | meaning
// IDLE  | waiting for START; LEN captured here
// ACCUM | accepting I0 terms until len_q have been summed
// HOLD  | result on Q with OVALID until ORDY
module clbacc #(
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 0,
  parameter int SAT      = 1,
  parameter int MODE_ACC = 0
) (
  input  logic        C,
  input  logic        R,
  input  logic        START,
  input  logic [7:0]  LEN,
  input  logic        CLR,
  input  logic [15:0] I0,
  input  logic        IVALID,
  output logic        IREADY,
  output logic [15:0] Q,
  output logic        OVALID,
  input  logic        ORDY,
  output logic        OVF,
  output logic        BUSY
);

  if (ACC_W < 17 || ACC_W > 32 || SHIFT < 0 || SHIFT > ACC_W - 16 || MODE_ACC < 0) begin : g_bad_cfg
    $error("clbacc: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic signed [ACC_W-1:0] QMAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] QMIN = -ACC_W'(32768);

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [7:0]               cnt;
  logic [7:0]               len_q;

  logic                     xfer;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  scaled;
  logic [15:0]              q_fmt;
  logic                     ovf_fmt;

  assign xfer = (state == ACCUM) & IVALID & IREADY;

  // Result is formed from the sum that includes the term being accepted now,
  // so Q is ready on the same edge that enters HOLD.
  always_comb begin
    acc_sum = acc + {{(ACC_W-16){I0[15]}}, I0};
    scaled  = acc_sum >>> SHIFT;
    q_fmt   = scaled[15:0];
    ovf_fmt = 1'b0;
    if (SAT != 0) begin
      if (scaled > QMAX) begin
        q_fmt   = 16'h7FFF;
        ovf_fmt = 1'b1;
      end else if (scaled < QMIN) begin
        q_fmt   = 16'h8000;
        ovf_fmt = 1'b1;
      end
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      len_q  <= '0;
      Q      <= '0;
      OVALID <= 1'b0;
      IREADY <= 1'b0;
      OVF    <= 1'b0;
      BUSY   <= 1'b0;
    end else if (CLR) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      OVALID <= 1'b0;
      IREADY <= 1'b0;
      OVF    <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= LEN;
            BUSY  <= 1'b1;
            if (LEN == 8'd0) begin
              state  <= HOLD;
              Q      <= '0;
              OVF    <= 1'b0;
              OVALID <= 1'b1;
            end else begin
              state  <= ACCUM;
              IREADY <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc <= acc_sum;
            cnt <= cnt + 8'd1;
            if (cnt == len_q - 8'd1) begin
              state  <= HOLD;
              Q      <= q_fmt;
              OVF    <= ovf_fmt;
              OVALID <= 1'b1;
              IREADY <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (ORDY) begin
            state  <= IDLE;
            OVALID <= 1'b0;
            OVF    <= 1'b0;
            BUSY   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          OVALID <= 1'b0;
          IREADY <= 1'b0;
          OVF    <= 1'b0;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule
